// File: rtl/memaccess.sv
// MEM-stage data-memory access unit: word-addressed RAM with a fixed number of
// wait states, a stall to freeze upstream stages, and the MEM/WB output register.
module memaccess #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        i_clk_l,
    input  logic        i_rst,
    input  logic        i_toWB,
    input  logic        i_memWRITE,
    input  logic        i_memToREG,
    input  logic [31:0] i_ALUout,
    input  logic [31:0] i_datamem,
    input  logic [4:0]  i_rd3,
    output logic        o_stall,
    output logic        o_toWB,
    output logic        o_memToREG,
    output logic [31:0] o_ALUout,
    output logic [31:0] o_readdata,
    output logic [4:0]  o_rd3,
    output logic        o_misalign
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT4     = 4'(LATENCY);
    localparam bit         HAS_WAIT = (LATENCY != 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [31:0]           ram [DEPTH];

    logic                  access;
    logic                  aligned;
    logic [DEPTH_LOG2-1:0] wordIdx;
    logic                  startWait;
    logic                  holdWait;
    logic                  complete;
    logic                  ramWrite;
    logic [31:0]           ramRd;

    assign access    = i_memWRITE | i_memToREG;
    assign aligned   = (i_ALUout[1:0] == 2'b00);
    assign wordIdx   = i_ALUout[DEPTH_LOG2+1:2];
    assign startWait = (state_q == IDLE) && access && aligned && HAS_WAIT;
    assign holdWait  = (state_q == BUSY) && (cnt_q != 4'd0);
    assign o_stall   = ~i_rst & (startWait | holdWait);
    assign complete  = ~i_rst & ~startWait & ~holdWait;
    assign ramWrite  = complete & i_memWRITE & aligned;
    assign ramRd     = ram[wordIdx];

    // RAM is not reset; the output register samples ramRd before this write lands,
    // which gives read-before-write when load and store coincide.
    always_ff @(posedge i_clk_l) begin
        if (ramWrite) begin
            ram[wordIdx] <= i_datamem;
        end
    end

    always_ff @(posedge i_clk_l) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            o_toWB     <= 1'b0;
            o_memToREG <= 1'b0;
            o_ALUout   <= 32'd0;
            o_readdata <= 32'd0;
            o_rd3      <= 5'd0;
            o_misalign <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startWait) begin
                        cnt_q   <= LAT4 - 4'd1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (!complete) begin
                o_toWB     <= 1'b0;
                o_memToREG <= 1'b0;
                o_misalign <= 1'b0;
            end else begin
                o_memToREG <= i_memToREG;
                o_ALUout   <= i_ALUout;
                o_rd3      <= i_rd3;
                if (access && !aligned) begin
                    o_toWB     <= i_toWB & ~i_memToREG;
                    o_readdata <= 32'd0;
                    o_misalign <= 1'b1;
                end else begin
                    o_toWB     <= i_toWB;
                    o_misalign <= 1'b0;
                    if (i_memToREG) begin
                        o_readdata <= ramRd;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_memaccess.sv
// Directed bench for memaccess: three instances (LATENCY 2, 0, 4) share one
// clock and reset; only the selected instance sees memory requests.
module tb_memaccess;

    logic        clk = 1'b0;
    logic        rst;
    logic        toWB, memWrite, memToReg;
    logic [31:0] aluOut, dataMem;
    logic [4:0]  rd3;
    logic [2:0]  en;

    logic        stallA   [3];
    logic        toWBA    [3];
    logic        memRegA  [3];
    logic [31:0] aluA     [3];
    logic [31:0] readA    [3];
    logic [4:0]  rdA      [3];
    logic        misA     [3];

    int checks   = 0;
    int failures = 0;
    int cur      = 0;
    int stalls;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        memaccess #(
            .DEPTH_LOG2(8),
            .LATENCY   ((g == 0) ? 2 : ((g == 1) ? 0 : 4))
        ) dut (
            .i_clk_l   (clk),
            .i_rst     (rst),
            .i_toWB    (toWB),
            .i_memWRITE(memWrite & en[g]),
            .i_memToREG(memToReg & en[g]),
            .i_ALUout  (aluOut),
            .i_datamem (dataMem),
            .i_rd3     (rd3),
            .o_stall   (stallA[g]),
            .o_toWB    (toWBA[g]),
            .o_memToREG(memRegA[g]),
            .o_ALUout  (aluA[g]),
            .o_readdata(readA[g]),
            .o_rd3     (rdA[g]),
            .o_misalign(misA[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s (inst %0d): got 0x%08h, expected 0x%08h", tag, cur, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic t, input logic w, input logic r,
                                 input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        toWB = t; memWrite = w; memToReg = r; aluOut = a; dataMem = d; rd3 = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts stall cycles until the held access completes, checking the bubble.
    task automatic runAccess(output int n);
        bit done = 0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!stallA[cur]) begin
                done = 1;
                break;
            end
            n++;
            tick();
            checkOutput("bubbleToWB", 32'(toWBA[cur]), 32'd0);
            checkOutput("bubbleMemToReg", 32'(memRegA[cur]), 32'd0);
        end
        if (!done) checkOutput("stallTimeout", 32'(n), 32'd0);
        tick();
    endtask

    task automatic nopCycle();
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 5'd0);
        tick();
    endtask

    initial begin
        en = 3'b111;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
            #2;
            for (int k = 0; k < 3; k++) begin
                cur = k;
                checkOutput("rstStall", 32'(stallA[k]), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) begin
            cur = k;
            checkOutput("rstToWB", 32'(toWBA[k]), 32'd0);
            checkOutput("rstMemToReg", 32'(memRegA[k]), 32'd0);
            checkOutput("rstALUout", aluA[k], 32'd0);
            checkOutput("rstReaddata", readA[k], 32'd0);
            checkOutput("rstRd3", 32'(rdA[k]), 32'd0);
            checkOutput("rstMisalign", 32'(misA[k]), 32'd0);
        end
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 5'd0);
        rst = 1'b0;

        // ALU passthrough on the LATENCY=2 instance
        cur = 0; en = 3'b001;
        applyStimulus(1, 0, 0, 32'h0000_1234, 32'd0, 5'd7);
        runAccess(stalls);
        checkOutput("passStalls", 32'(stalls), 32'd0);
        checkOutput("passToWB", 32'(toWBA[0]), 32'd1);
        checkOutput("passALUout", aluA[0], 32'h0000_1234);
        checkOutput("passRd3", 32'(rdA[0]), 32'd7);

        applyStimulus(0, 1, 0, 32'h10, 32'hDEAD_BEEF, 5'd0);
        runAccess(stalls);
        checkOutput("storeStalls", 32'(stalls), 32'd2);
        checkOutput("storeALUout", aluA[0], 32'h10);

        applyStimulus(1, 0, 1, 32'h10, 32'd0, 5'd9);
        runAccess(stalls);
        checkOutput("loadStalls", 32'(stalls), 32'd2);
        checkOutput("loadData", readA[0], 32'hDEAD_BEEF);
        checkOutput("loadMemToReg", 32'(memRegA[0]), 32'd1);
        checkOutput("loadRd3", 32'(rdA[0]), 32'd9);
        checkOutput("loadToWB", 32'(toWBA[0]), 32'd1);
        nopCycle();

        // Misaligned load and store on the LATENCY=2 instance
        applyStimulus(1, 0, 1, 32'h13, 32'd0, 5'd3);
        runAccess(stalls);
        checkOutput("misLoadStalls", 32'(stalls), 32'd0);
        checkOutput("misLoadFlag", 32'(misA[0]), 32'd1);
        checkOutput("misLoadData", readA[0], 32'd0);
        checkOutput("misLoadToWB", 32'(toWBA[0]), 32'd0);
        nopCycle();
        checkOutput("misFlagClears", 32'(misA[0]), 32'd0);
        applyStimulus(0, 1, 0, 32'h12, 32'hFFFF_FFFF, 5'd0);
        runAccess(stalls);
        checkOutput("misStoreStalls", 32'(stalls), 32'd0);
        checkOutput("misStoreFlag", 32'(misA[0]), 32'd1);
        nopCycle();
        applyStimulus(1, 0, 1, 32'h10, 32'd0, 5'd4);
        runAccess(stalls);
        checkOutput("word4Unchanged", readA[0], 32'hDEAD_BEEF);
        nopCycle();

        // LATENCY=0: no stall, address wrap and read-before-write
        cur = 1; en = 3'b010;
        applyStimulus(0, 1, 0, 32'h10, 32'hA5A5_A5A5, 5'd0);
        runAccess(stalls);
        checkOutput("lat0StoreStalls", 32'(stalls), 32'd0);
        applyStimulus(1, 0, 1, 32'h410, 32'd0, 5'd2);
        runAccess(stalls);
        checkOutput("lat0LoadStalls", 32'(stalls), 32'd0);
        checkOutput("wrapData", readA[1], 32'hA5A5_A5A5);
        applyStimulus(1, 1, 1, 32'h10, 32'h1111_2222, 5'd2);
        runAccess(stalls);
        checkOutput("rbwOldData", readA[1], 32'hA5A5_A5A5);
        applyStimulus(1, 0, 1, 32'h10, 32'd0, 5'd2);
        runAccess(stalls);
        checkOutput("rbwNewData", readA[1], 32'h1111_2222);
        nopCycle();

        // LATENCY=4: reset on stall cycle 2 aborts the store
        cur = 2; en = 3'b100;
        applyStimulus(0, 1, 0, 32'h20, 32'h0000_0077, 5'd0);
        runAccess(stalls);
        checkOutput("lat4Stalls", 32'(stalls), 32'd4);
        applyStimulus(0, 1, 0, 32'h20, 32'h0000_0001, 5'd0);
        #1;
        checkOutput("abortStall1", 32'(stallA[2]), 32'd1);
        tick();
        checkOutput("abortStall2", 32'(stallA[2]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 5'd0);
        #1;
        checkOutput("abortStallLow", 32'(stallA[2]), 32'd0);
        tick();
        checkOutput("abortStallIdle", 32'(stallA[2]), 32'd0);
        applyStimulus(1, 0, 1, 32'h20, 32'd0, 5'd5);
        runAccess(stalls);
        checkOutput("abortLoadStalls", 32'(stalls), 32'd4);
        checkOutput("abortPriorData", readA[2], 32'h0000_0077);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
